// File: rtl/alu_disp_pkg.sv
// rtl/alu_disp_pkg.sv - shared types, page constants and page wrap helper for the ALU display scanner
package alu_disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_AUTO   = 2'd1,
        S_MANUAL = 2'd2
    } state_t;

    localparam logic [2:0] PAGE_B0    = 3'd0;
    localparam logic [2:0] PAGE_B3    = 3'd3;
    localparam logic [2:0] PAGE_FLAGS = 3'd4;

    // Flag page wraps back to byte 0; unused codes 5..7 also recover to byte 0.
    function automatic logic [2:0] next_page(input logic [2:0] page);
        if (page >= PAGE_FLAGS) begin
            return PAGE_B0;
        end
        return page + 3'd1;
    endfunction

endpackage

// File: rtl/alu_disp_dwell_timer.sv
// rtl/alu_disp_dwell_timer.sv - dwell counter producing a one-cycle expire pulse every DWELL_CYCLES
module alu_disp_dwell_timer #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last  = (cnt_q == CNT_LAST);
    assign expire_o = en_i && !clear_i && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_display_scanner.sv
// rtl/alu_display_scanner.sv - snapshots ALU result/flags and scans the LED page select auto or manually
module alu_display_scanner
    import alu_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] f_in,
    input  logic        zf_in,
    input  logic        of_in,
    input  logic        capture,
    input  logic        mode,
    input  logic        step_btn,
    output logic [31:0] F,
    output logic        ZF,
    output logic        OF,
    output logic [2:0]  F_LED_SW,
    output logic        snap_valid
);

    state_t      state_q;
    state_t      mode_state;
    logic [2:0]  page_q;
    logic [31:0] f_q;
    logic        zf_q;
    logic        of_q;
    logic        valid_q;
    logic        step_q;
    logic        step_rise;
    logic        mode_change;
    logic        dwell_expire;
    logic        timer_clear;
    logic        timer_en;

    assign mode_state  = mode ? S_MANUAL : S_AUTO;
    assign step_rise   = step_btn && !step_q;
    assign mode_change = (state_q == S_AUTO   &&  mode) ||
                         (state_q == S_MANUAL && !mode);

    // The timer only runs while auto-scanning; any state transition restarts the dwell.
    assign timer_en    = (state_q == S_AUTO);
    assign timer_clear = capture || mode_change || (state_q != S_AUTO);

    alu_disp_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (timer_clear),
        .en_i     (timer_en),
        .expire_o (dwell_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            page_q  <= PAGE_B0;
            f_q     <= '0;
            zf_q    <= 1'b0;
            of_q    <= 1'b0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            step_q <= step_btn;
            if (capture) begin
                f_q     <= f_in;
                zf_q    <= zf_in;
                of_q    <= of_in;
                valid_q <= 1'b1;
                page_q  <= PAGE_B0;
                state_q <= mode_state;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        page_q <= PAGE_B0;
                    end
                    S_AUTO: begin
                        if (mode_change) begin
                            state_q <= mode_state;
                        end else if (dwell_expire) begin
                            page_q <= next_page(page_q);
                        end
                    end
                    S_MANUAL: begin
                        if (mode_change) begin
                            state_q <= mode_state;
                        end else if (step_rise) begin
                            page_q <= next_page(page_q);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        page_q  <= PAGE_B0;
                    end
                endcase
            end
        end
    end

    assign F          = f_q;
    assign ZF         = zf_q;
    assign OF         = of_q;
    assign F_LED_SW   = page_q;
    assign snap_valid = valid_q;

endmodule
